// File: rtl/dpram_be.sv
// True dual-port byte-writable word RAM with per-port request/ack, fault flags and
// optional extra output register.
module dpram_be #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 32,
  parameter int    DEPTH_LOG2 = 5,
  parameter int    RDW_MODE   = 0,
  parameter int    OUT_REG    = 0,
  parameter string INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_a,
  input  logic                    we_a,
  input  logic [DATA_WIDTH/8-1:0] be_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   data_a,
  output logic [DATA_WIDTH-1:0]   q_a,
  output logic                    rvalid_a,
  output logic                    err_a,
  input  logic                    req_b,
  input  logic                    we_b,
  input  logic [DATA_WIDTH/8-1:0] be_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH-1:0]   data_b,
  output logic [DATA_WIDTH-1:0]   q_b,
  output logic                    rvalid_b,
  output logic                    err_b
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(NB);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] ram [DEPTH];

  // Index 0 = port A, index 1 = port B; index order also sets write priority.
  logic                  req_p    [2];
  logic                  we_p     [2];
  logic [NB-1:0]         be_p     [2];
  logic [ADDR_WIDTH-1:0] addr_p   [2];
  logic [DATA_WIDTH-1:0] data_p   [2];
  logic [DATA_WIDTH-1:0] q_p      [2];
  logic                  rvalid_p [2];
  logic                  err_p    [2];
  logic [DEPTH_LOG2-1:0] idx_p    [2];
  logic                  wr_p     [2];

  assign req_p[0]  = req_a;
  assign we_p[0]   = we_a;
  assign be_p[0]   = be_a;
  assign addr_p[0] = addr_a;
  assign data_p[0] = data_a;
  assign req_p[1]  = req_b;
  assign we_p[1]   = we_b;
  assign be_p[1]   = be_b;
  assign addr_p[1] = addr_b;
  assign data_p[1] = data_b;

  assign q_a      = q_p[0];
  assign rvalid_a = rvalid_p[0];
  assign err_a    = err_p[0];
  assign q_b      = q_p[1];
  assign rvalid_b = rvalid_p[1];
  assign err_b    = err_p[1];

  function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [NB-1:0] be);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

  // Port B is applied last, so it owns lanes both ports enable on the same word.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_p[p] && be_p[p][i]) ram[idx_p[p]][i*8 +: 8] <= data_p[p][i*8 +: 8];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic                  fault;
      logic                  s1_valid;
      logic                  s1_err;
      logic                  s1_zero;
      logic                  s1_mw;
      logic [NB-1:0]         s1_be;
      logic [DATA_WIDTH-1:0] s1_wd;
      logic [DATA_WIDTH-1:0] s1_word;
      logic [DATA_WIDTH-1:0] s1_mask;
      logic [DATA_WIDTH-1:0] s1_q;

      assign fault = ((addr_p[gi] & ADDR_WIDTH'(NB - 1)) != '0) ||
                     ((addr_p[gi] >> (DEPTH_LOG2 + OFF)) != '0);
      assign idx_p[gi] = addr_p[gi][DEPTH_LOG2+OFF-1:OFF];
      assign wr_p[gi]  = req_p[gi] && we_p[gi] && !fault && !rst;

      // Plain registered read keeps the array mappable to block RAM; always the old word.
      always_ff @(posedge clk) begin
        if (req_p[gi] && !rst) s1_word <= ram[idx_p[gi]];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_valid <= 1'b0;
          s1_err   <= 1'b0;
          s1_zero  <= 1'b1;
          s1_mw    <= 1'b0;
        end else begin
          s1_valid <= req_p[gi];
          s1_err   <= req_p[gi] && fault;
          if (req_p[gi]) begin
            s1_zero <= fault;
            s1_mw   <= we_p[gi] && (RDW_MODE != 0);
            s1_be   <= be_p[gi];
            s1_wd   <= data_p[gi];
          end
        end
      end

      // New-data ack is rebuilt from the old word plus the captured write lanes.
      assign s1_mask = lane_mask(s1_be);
      assign s1_q    = s1_zero ? '0 :
                       s1_mw   ? ((s1_word & ~s1_mask) | (s1_wd & s1_mask)) : s1_word;

      if (OUT_REG != 0) begin : g_oreg
        logic                  s2_valid;
        logic                  s2_err;
        logic [DATA_WIDTH-1:0] s2_q;

        always_ff @(posedge clk) begin
          if (rst) begin
            s2_valid <= 1'b0;
            s2_err   <= 1'b0;
            s2_q     <= '0;
          end else begin
            s2_valid <= s1_valid;
            s2_err   <= s1_err;
            if (s1_valid) s2_q <= s1_q;
          end
        end

        assign q_p[gi]      = s2_q;
        assign rvalid_p[gi] = s2_valid;
        assign err_p[gi]    = s2_err;
      end else begin : g_direct
        assign q_p[gi]      = s1_q;
        assign rvalid_p[gi] = s1_valid;
        assign err_p[gi]    = s1_err;
      end
    end
  endgenerate

  logic unused_init;
  assign unused_init = (INIT_FILE == "");

endmodule

// File: tb/tb_dpram_be.sv
// Bench for dpram_be: one default instance (old-data, latency 1) and one
// new-data/latency-2 instance share stimulus and are checked against a word-array model.
module tb_dpram_be;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, we_a, req_b, we_b;
  logic [3:0]  be_a, be_b;
  logic [31:0] addr_a, data_a, addr_b, data_b;
  logic [31:0] q0a, q0b, q1a, q1b;
  logic        v0a, v0b, v1a, v1b, e0a_o, e0b_o, e1a_o, e1b_o;

  always #5 clk = ~clk;

  dpram_be #(.RDW_MODE(0), .OUT_REG(0)) d0 (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a),
    .q_a(q0a), .rvalid_a(v0a), .err_a(e0a_o),
    .req_b(req_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b),
    .q_b(q0b), .rvalid_b(v0b), .err_b(e0b_o));

  dpram_be #(.RDW_MODE(1), .OUT_REG(1)) d1 (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a),
    .q_a(q1a), .rvalid_a(v1a), .err_a(e1a_o),
    .req_b(req_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b),
    .q_b(q1b), .rvalid_b(v1b), .err_b(e1b_o));

  typedef struct { logic req; logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] data; } op_t;
  typedef struct { logic v; logic e; logic [31:0] q; bit qk; } rsp_t;
  typedef struct { op_t a; op_t b; logic va; logic ea; logic [31:0] qa; logic vb; logic eb; logic [31:0] qb; } vec_t;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [31:0] mem [32];
  bit          kn  [32];
  rsp_t e0a, e0b, e1a, e1b, p1a, p1b;

  function automatic op_t mk(logic req, logic we, logic [3:0] be, logic [31:0] addr, logic [31:0] data);
    op_t o;
    o.req = req; o.we = we; o.be = be; o.addr = addr; o.data = data;
    return o;
  endfunction

  function automatic rsp_t zero_r();
    rsp_t r;
    r.v = 1'b0; r.e = 1'b0; r.q = 32'h0; r.qk = 1'b1;
    return r;
  endfunction

  function automatic rsp_t hold(rsp_t x);
    rsp_t r;
    r = x; r.v = 1'b0; r.e = 1'b0;
    return r;
  endfunction

  function automatic bit faulty(logic [31:0] addr);
    return (addr % 4 != 0) || (addr >= 32'd128);
  endfunction

  function automatic rsp_t model_rsp(op_t o, bit rdw);
    rsp_t r;
    int w;
    r.v = o.req;
    r.e = o.req && faulty(o.addr);
    w = int'(o.addr / 4) % 32;
    if (faulty(o.addr)) begin
      r.q = 32'h0; r.qk = 1'b1;
    end else begin
      r.q = mem[w]; r.qk = kn[w];
      if (o.we && rdw) begin
        for (int i = 0; i < 4; i++) if (o.be[i]) r.q[i*8 +: 8] = o.data[i*8 +: 8];
        r.qk = kn[w] || (o.be == 4'hF);
      end
    end
    return r;
  endfunction

  task automatic mem_write(op_t o);
    int w;
    if (o.req && o.we && !faulty(o.addr)) begin
      w = int'(o.addr / 4);
      for (int i = 0; i < 4; i++) if (o.be[i]) mem[w][i*8 +: 8] = o.data[i*8 +: 8];
      kn[w] = kn[w] || (o.be == 4'hF);
    end
  endtask

  task automatic chk(string nm, logic v, logic e, logic [31:0] q, rsp_t x);
    checks++;
    if (v !== x.v || e !== x.e || (x.qk && q !== x.q)) begin
      fails++;
      $display("FAIL %s: got v=%b e=%b q=%h, want v=%b e=%b q=%h", nm, v, e, q, x.v, x.e, x.q);
    end else passes++;
  endtask

  task automatic xchk(string nm, logic [33:0] got, logic [33:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end else passes++;
  endtask

  // One clock cycle: drive, advance the model, check every output at the falling edge.
  task automatic step(bit r, op_t a, op_t b);
    rsp_t n0a, n0b, n1a, n1b;
    rst = r;
    req_a = a.req; we_a = a.we; be_a = a.be; addr_a = a.addr; data_a = a.data;
    req_b = b.req; we_b = b.we; be_b = b.be; addr_b = b.addr; data_b = b.data;
    n0a = model_rsp(a, 1'b0); n0b = model_rsp(b, 1'b0);
    n1a = model_rsp(a, 1'b1); n1b = model_rsp(b, 1'b1);
    if (!r) begin
      mem_write(a);
      mem_write(b);
    end
    @(posedge clk);
    if (r) begin
      e0a = zero_r(); e0b = zero_r(); e1a = zero_r(); e1b = zero_r();
      p1a = zero_r(); p1b = zero_r();
    end else begin
      e0a = a.req ? n0a : hold(e0a);
      e0b = b.req ? n0b : hold(e0b);
      e1a = p1a.v ? p1a : hold(e1a);
      e1b = p1b.v ? p1b : hold(e1b);
      p1a = a.req ? n1a : zero_r();
      p1b = b.req ? n1b : zero_r();
    end
    @(negedge clk);
    chk("d0_a", v0a, e0a_o, q0a, e0a);
    chk("d0_b", v0b, e0b_o, q0b, e0b);
    chk("d1_a", v1a, e1a_o, q1a, e1a);
    chk("d1_b", v1b, e1b_o, q1b, e1b);
  endtask

  vec_t tbl [12];
  op_t  idle;

  initial begin
    idle = mk(0, 0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 32; i++) begin mem[i] = 32'h0; kn[i] = 1'b0; end
    p1a = zero_r(); p1b = zero_r();
    e0a = zero_r(); e0b = zero_r(); e1a = zero_r(); e1b = zero_r();

    // Reset held two cycles with both ports requesting.
    for (int k = 0; k < 2; k++) begin
      step(1, mk(1, 1, 4'hF, 32'h0C, 32'hDEADBEEF), mk(1, 0, 4'h0, 32'h10, 32'h0));
      xchk("rst_d0", {v0a, v0b, e0a_o, e0b_o, q0a[29:0]}, 34'h0);
      xchk("rst_d1", {v1a, v1b, e1a_o, e1b_o, q1a[29:0]}, 34'h0);
      xchk("rst_q", {2'b00, q0b | q1b}, 34'h0);
    end
    for (int k = 0; k < 2; k++) begin
      step(0, idle, idle);
      xchk("post_rst_valid", {30'h0, v0a, v0b, v1a, v1b}, 34'h0);
    end

    for (int w = 0; w < 32; w++) step(0, idle, mk(1, 1, 4'hF, 32'(w * 4), 32'h0));

    tbl[0]  = '{mk(0,0,4'h0,32'h00,0),          mk(1,1,4'hF,32'h10,32'hAABBCCDD), 0,0,32'h0,        1,0,32'h0};
    tbl[1]  = '{mk(0,0,4'h0,32'h00,0),          mk(1,1,4'h2,32'h10,32'h00001100), 0,0,32'h0,        1,0,32'hAABBCCDD};
    tbl[2]  = '{mk(1,0,4'h0,32'h10,0),          mk(0,0,4'h0,32'h00,0),            1,0,32'hAABB11DD, 0,0,32'hAABBCCDD};
    tbl[3]  = '{mk(0,0,4'h0,32'h00,0),          mk(1,1,4'hF,32'h08,32'h11111111), 0,0,32'hAABB11DD, 1,0,32'h0};
    tbl[4]  = '{mk(1,1,4'hF,32'h08,32'h22222222), mk(1,0,4'h0,32'h08,0),          1,0,32'h11111111, 1,0,32'h11111111};
    tbl[5]  = '{mk(1,0,4'h0,32'h08,0),          mk(0,0,4'h0,32'h00,0),            1,0,32'h22222222, 0,0,32'h11111111};
    tbl[6]  = '{mk(1,1,4'hF,32'h04,32'h12345678), mk(1,1,4'h3,32'h04,32'hCAFEBABE), 1,0,32'h0,      1,0,32'h0};
    tbl[7]  = '{mk(1,0,4'h0,32'h04,0),          mk(0,0,4'h0,32'h00,0),            1,0,32'h1234BABE, 0,0,32'h0};
    tbl[8]  = '{mk(1,0,4'h0,32'h06,0),          mk(1,0,4'h0,32'h80,0),            1,1,32'h0,        1,1,32'h0};
    tbl[9]  = '{mk(1,0,4'h0,32'h00,0),          mk(1,1,4'hF,32'h80,32'hFFFFFFFF), 1,0,32'h0,        1,1,32'h0};
    tbl[10] = '{mk(1,0,4'h0,32'h00,0),          mk(1,1,4'h0,32'h10,32'hFFFFFFFF), 1,0,32'h0,        1,0,32'hAABB11DD};
    tbl[11] = '{mk(1,0,4'h0,32'h10,0),          mk(0,0,4'h0,32'h00,0),            1,0,32'hAABB11DD, 0,0,32'hAABB11DD};
    for (int i = 0; i < 12; i++) begin
      step(0, tbl[i].a, tbl[i].b);
      xchk($sformatf("tbl%0d_a", i), {v0a, e0a_o, q0a}, {tbl[i].va, tbl[i].ea, tbl[i].qa});
      xchk($sformatf("tbl%0d_b", i), {v0b, e0b_o, q0b}, {tbl[i].vb, tbl[i].eb, tbl[i].qb});
    end

    // New-data ack on the latency-2 instance, old word on the cross port.
    step(0, idle, mk(1, 1, 4'hF, 32'h08, 32'h11111111));
    step(0, mk(1, 1, 4'hF, 32'h08, 32'h22222222), mk(1, 0, 4'h0, 32'h08, 0));
    step(0, idle, idle);
    xchk("rdw1_a", {v1a, e1a_o, q1a}, {2'b10, 32'h22222222});
    xchk("rdw1_b", {v1b, e1b_o, q1b}, {2'b10, 32'h11111111});

    // Mid-run reset: in-flight and reset-cycle requests get no ack and no write.
    step(0, mk(1, 0, 4'h0, 32'h10, 0), idle);
    step(1, mk(1, 1, 4'hF, 32'h0C, 32'hDEADBEEF), mk(1, 1, 4'hF, 32'h0C, 32'hDEADBEEF));
    step(0, idle, idle);
    xchk("flush_valid", {30'h0, v0a, v0b, v1a, v1b}, 34'h0);
    step(0, mk(1, 0, 4'h0, 32'h0C, 0), idle);
    xchk("rst_nowrite", {v0a, e0a_o, q0a}, {2'b10, 32'h0});

    // Eight back-to-back reads through the latency-2 instance.
    for (int w = 0; w < 8; w++) step(0, idle, mk(1, 1, 4'hF, 32'(w * 4), 32'hA5A50000 | 32'(w)));
    for (int k = 0; k < 10; k++) begin
      step(0, (k < 8) ? mk(1, 0, 4'h0, 32'(k * 4), 0) : idle, idle);
      if (k >= 1 && k <= 8)
        xchk($sformatf("tput%0d", k), {1'b0, v1a, q1a}, {2'b01, 32'hA5A50000 | 32'(k - 1)});
      else
        xchk($sformatf("tput%0d", k), {33'h0, v1a}, 34'h0);
    end

    // Randomized traffic biased toward collisions and faults.
    for (int n = 0; n < 600; n++) begin
      op_t ro [2];
      for (int p = 0; p < 2; p++) begin
        int sel;
        logic [31:0] ad;
        sel = $urandom_range(0, 15);
        if (sel == 0)      ad = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
        else if (sel == 1) ad = ($urandom | 32'h80) & 32'hFFFFFFFC;
        else if (sel < 10) ad = 32'($urandom_range(0, 7) * 4);
        else               ad = 32'($urandom_range(0, 31) * 4);
        ro[p] = mk(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                   4'($urandom_range(0, 15)), ad, $urandom);
      end
      step($urandom_range(0, 49) == 0, ro[0], ro[1]);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
